// File: rtl/logic_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_pkg
// Description : Shared op codes and helpers for the logic_gate_pipe datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_gate_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND     = 3'd0;
  localparam op_t OP_OR      = 3'd1;
  localparam op_t OP_NOR     = 3'd2;
  localparam op_t OP_NAND    = 3'd3;
  localparam op_t OP_XOR     = 3'd4;
  localparam op_t OP_XNOR    = 3'd5;
  localparam op_t OP_NOT     = 3'd6;
  localparam op_t OP_ILLEGAL = 3'd7;

  // Lane count must stay within the range the reduction tree was sized for.
  function automatic bit n_in_legal(input int n);
    return (n >= 2) && (n <= 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_gate_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_pipe_if
// Description : Input/output valid-ready bus of the logic_gate_pipe stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_gate_pipe_if
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2
);
  logic                  in_valid;
  logic                  in_ready;
  op_t                   in_op;
  logic [N_IN*WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  op_t                   out_op;

  // Producer/consumer side driving transactions into the stage.
  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_op
  );

  // The pipeline stage itself.
  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, out_data, out_op
  );
endinterface
`default_nettype wire

// File: rtl/logic_gate_pipe_gate_reduce.sv
`default_nettype none
// ============================================================================
// Module      : gate_reduce
// Description : Combinational bitwise reduction of N_IN lanes by op code.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_reduce
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2
) (
  input  op_t                   op,
  input  logic [N_IN*WIDTH-1:0] lanes,
  output logic [WIDTH-1:0]      result
);

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;

  // Fold all lanes into AND/OR/XOR reductions, then pick by op code.
  always_comb begin
    w_and = lanes[WIDTH-1:0];
    w_or  = lanes[WIDTH-1:0];
    w_xor = lanes[WIDTH-1:0];
    for (int k = 1; k < N_IN; k++) begin
      w_and = w_and & lanes[k*WIDTH +: WIDTH];
      w_or  = w_or  | lanes[k*WIDTH +: WIDTH];
      w_xor = w_xor ^ lanes[k*WIDTH +: WIDTH];
    end
    case (op)
      OP_AND:  result = w_and;
      OP_OR:   result = w_or;
      OP_NOR:  result = ~w_or;
      OP_NAND: result = ~w_and;
      OP_XOR:  result = w_xor;
      OP_XNOR: result = ~w_xor;
      OP_NOT:  result = ~lanes[WIDTH-1:0];
      default: result = '0;  // illegal op yields zero
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_pipe
// Description : Registered gate stage with 2-entry skid buffer, saturating
//               transfer counter and sticky illegal-op flag.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  logic_gate_pipe_if.slave   bus,
  output logic [CNT_W-1:0]   op_count,
  output logic               err_op
);

  if (!n_in_legal(N_IN)) begin : g_bad_n_in
    $error("logic_gate_pipe: N_IN must be in 2..8");
  end

  logic [WIDTH-1:0] w_result;
  logic             w_accept;
  logic             w_pop;
  logic             w_skid_valid_nxt;

  logic             r_in_ready;
  logic             r_main_valid;
  logic [WIDTH-1:0] r_main_data;
  op_t              r_main_op;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  op_t              r_skid_op;
  logic [CNT_W-1:0] r_op_count;
  logic             r_err_op;

  gate_reduce #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_reduce (
    .op     (bus.in_op),
    .lanes  (bus.in_data),
    .result (w_result)
  );

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_pop    = r_main_valid && bus.out_ready;

  // Skid fills only when an accept lands on a held main entry; it drains on
  // any pop. in_ready is the registered complement, so out_ready never
  // reaches in_ready combinationally.
  always_comb begin
    w_skid_valid_nxt = r_skid_valid;
    if (r_skid_valid && w_pop) begin
      w_skid_valid_nxt = 1'b0;
    end else if (!r_skid_valid && w_accept && r_main_valid && !w_pop) begin
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Main/skid entry update; a pop with a full skid cannot coincide with an
  // accept because in_ready is low whenever skid is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready   <= 1'b0;
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_op    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_op    <= '0;
    end else begin
      r_in_ready   <= !w_skid_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      if (w_pop) begin
        if (r_skid_valid) begin
          r_main_data <= r_skid_data;
          r_main_op   <= r_skid_op;
        end else if (w_accept) begin
          r_main_data <= w_result;
          r_main_op   <= bus.in_op;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_main_valid) begin
          r_main_valid <= 1'b1;
          r_main_data  <= w_result;
          r_main_op    <= bus.in_op;
        end else begin
          r_skid_data <= w_result;
          r_skid_op   <= bus.in_op;
        end
      end
    end
  end

  // Count completed output transfers, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_pop && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  // Sticky flag raised when an illegal op is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_op <= 1'b0;
    end else if (w_accept && (bus.in_op == OP_ILLEGAL)) begin
      r_err_op <= 1'b1;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_main_valid;
  assign bus.out_data  = r_main_data;
  assign bus.out_op    = r_main_op;
  assign op_count      = r_op_count;
  assign err_op        = r_err_op;

endmodule
`default_nettype wire

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
- Parametrised, pipelined successor to the team's single-bit two-input gates.
- Applies one of seven bitwise logic ops across N_IN operand lanes of WIDTH bits each. The op is selected per transaction.
- Valid/ready handshake on input and output; 2-entry skid buffer absorbs back-pressure without bubbles.
- Sits as a reusable datapath stage between producer/consumer blocks; also carries a result counter and a sticky illegal-op flag.

Parameters:
- WIDTH, 8, bit width of each operand lane and of the result.
- N_IN, 2, number of operand lanes; legal range 2..8.
- CNT_W, 16, width of the saturating result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a transaction.
- in_ready  output  1  block can accept a transaction this cycle.
- in_op  input  3  op code; see Behaviour.
- in_data  input  N_IN*WIDTH  operand lanes; lane k = in_data[k*WIDTH +: WIDTH].
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- out_op  output  3  op code that produced out_data.
- op_count  output  CNT_W  number of completed output transfers; saturates.
- err_op  output  1  sticky: an illegal op was accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Everything is sampled on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_op=0, op_count=0, err_op=0, both buffer entries empty. in_ready=0 while rst=1 and 1 in the first cycle after rst deasserts.
- Op codes, per bit across all lanes:
  - 0 AND, 1 OR, 2 NOR, 3 NAND, 4 XOR (odd parity), 5 XNOR (even parity).
  - 6 NOT: ~lane0; other lanes ignored.
  - 7 illegal: result is all zeros, err_op set.
- Accept: the input transfer occurs when in_valid && in_ready. The result is computed combinationally from in_data/in_op and registered; nothing else is captured.
- Latency: result is visible on out_data with out_valid=1 on the cycle after acceptance. Throughput is 1 per cycle while out_ready=1.
- Skid buffer: main entry drives the outputs; skid entry holds overflow.
  - in_ready = skid entry empty (registered; no combinational path from out_ready).
  - Accept with main empty, or main popping this cycle while skid is empty: result loads into main.
  - Accept while main is held (out_valid && !out_ready): result loads into skid; in_ready drops next cycle.
  - Pop (out_valid && out_ready) with skid full: skid moves to main, skid empties, in_ready returns to 1 next cycle.
  - Pop and accept in the same cycle with skid full: not possible, since in_ready=0.
- Output stability: while out_valid=1 && out_ready=0, out_data and out_op hold constant.
- op_count: increments by 1 on each output transfer; holds at 2^CNT_W-1 (no wrap).
- err_op: set on acceptance of op 7; cleared only by rst.
- Reset mid-operation: any buffered result is discarded. No output transfer occurs in the reset cycle and op_count does not increment.
- in_valid with in_ready=0: no effect. The producer must hold its data; the block does not check this.

Decomposition:
- Package logic_gate_pkg: op-code localparams (OP_AND..OP_ILLEGAL), op width constant 3, N_IN legality check macro/function.
- Sub-module gate_reduce: purely combinational. Parameters WIDTH, N_IN; inputs op and lanes; output result. It is the only place the op table lives.
- logic_gate_pipe holds the skid buffer, counter and err flag.

Test Plan (WIDTH=8, N_IN=3):
- Reset then idle: rst high 3 cycles -> all outputs 0, in_ready=0. After release -> in_ready=1, out_valid=0.
- All legal ops, out_ready=1, lanes 0xF0/0xCC/0xAA -> next cycle:
  - AND 0x80, OR 0xFE, NOR 0x01, NAND 0x7F
  - XOR 0x96, XNOR 0x69, NOT 0x0F
  - op_count=7 after the last result.
- Back-pressure: out_ready=0, send AND then OR -> out_data=0x80 held; in_ready=0 after the 2nd accept. Then raise out_ready -> 0x80 then 0xFE on consecutive cycles, no loss or duplication.
- Illegal op 7 -> out_data=0x00, out_op=7, err_op=1. err_op stays 1 through later legal ops; cleared only by rst.
- Counter saturation (CNT_W=4): 20 transfers -> op_count=15.
- Reset with both entries full -> next cycle out_valid=0, op_count=0, in_ready=1 one cycle after rst drops.
